ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares the single-ported unified word RAM between the instruction-fetch requester (port 0) and the load/store requester (port 1) of the multi-cycle core. Each port gets a req/gnt request handshake and an rvalid response. The block registers the winning command and drives the RAM address/enable/write-data for exactly one cycle. It captures the RAM's combinational read data into a response register and flags accesses outside the populated RAM range. It sits between the core's control/datapath and the RAM on the mother board.

Parameters:
DATA_W, 32, data word width (bits)
ADDR_W, 32, byte address width
MEM_WORDS, 64, populated RAM depth in words; word index >= MEM_WORDS is out of range

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  port 0 (fetch) request
we0  in  1  port 0 write enable (0 = read)
addr0  in  ADDR_W  port 0 byte address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 request accepted this cycle
rvalid0  out  1  port 0 response valid (1-cycle pulse)
rerr0  out  1  port 0 out-of-range flag, valid with rvalid0
req1, we1, addr1, wdata1, gnt1, rvalid1, rerr1: port 1 (data), same as port 0
rdata  out  DATA_W  response data, shared; qualified by rvalid0/rvalid1
mem_addr  out  ADDR_W  RAM byte address
mem_enab  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- FSM states: IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: all gnt/rvalid/rerr = 0; rdata = 0; mem_addr = 0; mem_enab = 0; mem_wdata = 0; last_grant = 1, so port 0 wins the first tie.
- Acceptance:
  - gnt0/gnt1 are combinational and asserted only in IDLE or RESP, and only when the corresponding req = 1 and reset = 0.
  - At most one gnt is high per cycle.
  - When a gnt is high, the port's we/addr/wdata are sampled at that edge.
- Arbitration:
  - Only one port requests -> it wins.
  - Both request -> the port != last_grant wins (round-robin).
  - last_grant updates to the winner at the accepting edge.
- IDLE: a grant -> ACCESS; no request -> stay.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the registered command.
  - mem_enab = cmd_we AND in_range; the RAM write commits at the ACCESS->RESP edge.
  - rdata register <= mem_rdata if in_range, else 0. On writes, rdata is still loaded with mem_rdata, i.e. the old word.
  - Next state: RESP.
- RESP (1 cycle):
  - rvalid of the owning port = 1; rerr = NOT in_range.
  - A new grant may be issued in this cycle -> ACCESS; otherwise -> IDLE.
  - Back-to-back throughput: 1 access per 2 cycles.
- Latency: gnt in cycle N -> ACCESS in N+1 -> rvalid in N+2. A write is visible to a read granted in N+2 or later.
- Outside ACCESS, mem_enab = 0. mem_addr/mem_wdata hold their last value (don't-care).
- in_range = (cmd_addr[ADDR_W-1:2] < MEM_WORDS). Out-of-range writes are suppressed (mem_enab stays 0). Out-of-range reads return 0.
- Byte offset addr[1:0] is ignored: access is whole-word. It is passed unchanged on mem_addr.
- A requester must hold req/we/addr/wdata stable until gnt. Deasserting req before gnt withdraws the request with no side effect.
- A requester holding req high across RESP gets its next gnt in RESP, subject to round-robin.
- Reset in ACCESS: the state clears at that edge. mem_enab is still high during that cycle, so a write in progress completes. No rvalid is issued.
- Reset in RESP: rvalid is suppressed from the next cycle; the pending new grant is cancelled (gnt forced 0 while reset = 1).

Test Plan:
1. Reset, then req0 read addr 0x0 (RAM[0] = 0x12345678) -> gnt0 in N, mem_enab = 0 in N+1, rvalid0 = 1 with rdata = 0x12345678 and rerr0 = 0 in N+2.
2. req1 write addr 0x8, wdata 0xDEADBEEF, then req1 read 0x8 -> mem_enab = 1 only in the write's ACCESS cycle; the read returns 0xDEADBEEF; the write's response rdata = old RAM[2].
3. req0 and req1 both held high for 6 cycles after reset -> grants alternate 0,1,0 at cycles N, N+2, N+4; no cycle has both gnt high.
4. req1 write addr 0x100 (word 64 with MEM_WORDS = 64) -> mem_enab stays 0; rvalid1 = 1 with rerr1 = 1 and rdata = 0; RAM contents unchanged.
5. req0 read addr 0x6 -> rdata = RAM[1]; mem_addr = 0x6 during ACCESS.
6. Reset asserted during the ACCESS of a port 1 read -> no rvalid1 ever; the FSM is in IDLE after reset deasserts; a subsequent tie grants port 0 first.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Two requester ports (fetch, load/store) plus the RAM-side bus of the RAM arbiter.
// The slave modport is the arbiter's view; master is the core+RAM side.
interface ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic              rerr0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic              rerr1;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enab;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rerr0,
    output gnt1, rvalid1, rerr1,
    output rdata,
    output mem_addr, mem_enab, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rerr0,
    input  gnt1, rvalid1, rerr1,
    input  rdata,
    input  mem_addr, mem_enab, mem_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported word RAM between fetch (port 0)
// and load/store (port 1): IDLE/RESP accept, ACCESS drives the RAM for one cycle.
module ram_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              port;
    logic              we;
    logic              inr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [ADDR_W-3:0] LP_MEM_WORDS = (ADDR_W-2)'(MEM_WORDS);

  state_t            r_state;
  cmd_t              r_cmd;
  logic              r_last_grant;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_rerr;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_req;
  logic              w_can_gnt;
  logic [1:0]        w_gnt;
  cmd_t              w_sel;

  assign w_req     = {bus.req1, bus.req0};
  assign w_can_gnt = ((r_state == IDLE) || (r_state == RESP)) && !reset;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_gnt = 2'b00;
    if (w_can_gnt) begin
      case (w_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last_grant ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    w_sel.port  = w_gnt[1];
    w_sel.we    = w_gnt[1] ? bus.we1    : bus.we0;
    w_sel.addr  = w_gnt[1] ? bus.addr1  : bus.addr0;
    w_sel.wdata = w_gnt[1] ? bus.wdata1 : bus.wdata0;
    w_sel.inr   = (w_sel.addr[ADDR_W-1:2] < LP_MEM_WORDS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_last_grant <= 1'b1;
      r_rvalid     <= 2'b00;
      r_rerr       <= 2'b00;
      r_rdata      <= '0;
    end else begin
      r_rvalid <= 2'b00;
      r_rerr   <= 2'b00;
      case (r_state)
        IDLE, RESP: begin
          if (|w_gnt) begin
            r_state      <= ACCESS;
            r_cmd        <= w_sel;
            r_last_grant <= w_sel.port;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          // On writes this still captures the pre-write word.
          r_state                <= RESP;
          r_rvalid[r_cmd.port]   <= 1'b1;
          r_rerr[r_cmd.port]     <= !r_cmd.inr;
          r_rdata                <= r_cmd.inr ? bus.mem_rdata : '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = w_gnt[0];
  assign bus.gnt1      = w_gnt[1];
  assign bus.rvalid0   = r_rvalid[0];
  assign bus.rvalid1   = r_rvalid[1];
  assign bus.rerr0     = r_rerr[0];
  assign bus.rerr1     = r_rerr[1];
  assign bus.rdata     = r_rdata;

  // Address/data hold between accesses; the write strobe exists only in ACCESS.
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.mem_enab  = (r_state == ACCESS) && r_cmd.we && r_cmd.inr;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a cycle-level reference model.
module tb_ram_arbiter;
  localparam int NW = 64;

  logic clk;
  logic reset;
  logic load;

  ram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus();

  ram_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write committed at the clock edge
  logic [31:0] init_img [NW];
  logic [31:0] ram      [NW];
  logic [29:0] ram_w;
  assign ram_w         = bus.mem_addr[31:2];
  assign bus.mem_rdata = (ram_w < 30'd64) ? ram[ram_w[5:0]] : (32'hBAD0_0000 ^ {2'b00, ram_w});

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NW; i++) ram[i] <= init_img[i];
    end else if (bus.mem_enab && ram_w < 30'd64) begin
      ram[ram_w[5:0]] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [NW];
  int          cyc     = 0;
  int          next_ok = 0;
  bit          last    = 1'b1;
  int          acc_cyc = -1;
  bit          acc_en;
  logic [31:0] acc_addr, acc_wdata;

  initial begin
    bit          eg0, eg1, ev0, ev1, p, we, inr;
    logic [31:0] a, d;
    int unsigned w;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (load) for (int i = 0; i < NW; i++) shadow[i] = init_img[i];

      if (acc_cyc == cyc) begin
        chk(bus.mem_enab === acc_en, "mem_enab_access", {31'd0, bus.mem_enab}, {31'd0, acc_en});
        chk(bus.mem_addr === acc_addr, "mem_addr_access", bus.mem_addr, acc_addr);
        if (acc_en) chk(bus.mem_wdata === acc_wdata, "mem_wdata", bus.mem_wdata, acc_wdata);
      end else begin
        chk(bus.mem_enab === 1'b0, "mem_enab_idle", {31'd0, bus.mem_enab}, 32'd0);
      end

      ev0 = (q.size() > 0) && (q[0].due == cyc) && (q[0].port == 1'b0);
      ev1 = (q.size() > 0) && (q[0].due == cyc) && (q[0].port == 1'b1);
      chk(bus.rvalid0 === ev0, "rvalid0", {31'd0, bus.rvalid0}, {31'd0, ev0});
      chk(bus.rvalid1 === ev1, "rvalid1", {31'd0, bus.rvalid1}, {31'd0, ev1});
      if (ev0 || ev1) begin
        e = q.pop_front();
        chk(bus.rdata === e.data, "rdata", bus.rdata, e.data);
        if (e.port) chk(bus.rerr1 === e.err, "rerr1", {31'd0, bus.rerr1}, {31'd0, e.err});
        else        chk(bus.rerr0 === e.err, "rerr0", {31'd0, bus.rerr0}, {31'd0, e.err});
      end

      // One access per two cycles; ties alternate starting with port 0
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!reset && cyc >= next_ok) begin
        if (bus.req0 && bus.req1) begin
          if (last) eg0 = 1'b1; else eg1 = 1'b1;
        end else if (bus.req0) eg0 = 1'b1;
        else if (bus.req1) eg1 = 1'b1;
      end
      chk(bus.gnt0 === eg0, "gnt0", {31'd0, bus.gnt0}, {31'd0, eg0});
      chk(bus.gnt1 === eg1, "gnt1", {31'd0, bus.gnt1}, {31'd0, eg1});

      if (eg0 || eg1) begin
        p   = eg1;
        we  = p ? bus.we1    : bus.we0;
        a   = p ? bus.addr1  : bus.addr0;
        d   = p ? bus.wdata1 : bus.wdata0;
        w   = a >> 2;
        inr = (w < NW);
        e.port = p;
        e.data = inr ? shadow[w] : 32'd0;
        e.err  = !inr;
        e.due  = cyc + 2;
        q.push_back(e);
        if (we && inr) shadow[w] = d;
        acc_cyc   = cyc + 1;
        acc_en    = we && inr;
        acc_addr  = a;
        acc_wdata = d;
        last      = p;
        next_ok   = cyc + 2;
      end

      if (reset) begin
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        if (acc_cyc > cyc) acc_cyc = -1;
        next_ok = cyc + 1;
        last    = 1'b1;
      end
    end
  end

  task automatic issue(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (p) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (p ? bus.gnt1 : bus.gnt0) return;
    end
    chk(1'b0, "gnt_timeout", {31'd0, p}, 32'd0);
    if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  task automatic idle(input bit p, input int n);
    @(posedge clk); #1;
    if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return $urandom;
    if (sel == 1) return ($urandom_range(64, 200) << 2) | $urandom_range(0, 3);
    return ($urandom_range(0, NW-1) << 2) | $urandom_range(0, 3);
  endfunction

  task automatic rnd_port(input bit p, input int n);
    for (int i = 0; i < n; i++) begin
      issue(p, ($urandom_range(0, 2) == 0), rnd_addr(), $urandom);
      if ($urandom_range(0, 2) == 0) idle(p, $urandom_range(0, 2));
    end
    idle(p, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < NW; i++) init_img[i] = $urandom;
    init_img[0] = 32'h1234_5678;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    reset = 1'b1;
    load  = 1'b1;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk(bus.gnt0 === 1'b0,    "rst_gnt0",      {31'd0, bus.gnt0}, 32'd0);
    chk(bus.rvalid0 === 1'b0, "rst_rvalid0",   {31'd0, bus.rvalid0}, 32'd0);
    chk(bus.rvalid1 === 1'b0, "rst_rvalid1",   {31'd0, bus.rvalid1}, 32'd0);
    chk(bus.rerr0 === 1'b0,   "rst_rerr0",     {31'd0, bus.rerr0}, 32'd0);
    chk(bus.rerr1 === 1'b0,   "rst_rerr1",     {31'd0, bus.rerr1}, 32'd0);
    chk(bus.rdata === 32'd0,  "rst_rdata",     bus.rdata, 32'd0);
    chk(bus.mem_addr === 32'd0,  "rst_mem_addr",  bus.mem_addr, 32'd0);
    chk(bus.mem_wdata === 32'd0, "rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req0 = 1'b0;

    // Directed: read word 0, write/readback, out-of-range write, unaligned read
    issue(0, 0, 32'h0, 32'h0);              idle(0, 0);
    issue(1, 1, 32'h8, 32'hDEAD_BEEF);
    issue(1, 0, 32'h8, 32'h0);              idle(1, 0);
    issue(1, 1, 32'h100, 32'hCAFE_F00D);
    issue(1, 0, 32'h100, 32'h0);            idle(1, 0);
    issue(0, 0, 32'h6, 32'h0);              idle(0, 1);

    // Both ports held: after reset grants must alternate starting with port 0
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fork
      begin repeat (3) issue(0, 0, rnd_addr(), 32'h0); idle(0, 0); end
      begin repeat (3) issue(1, 0, rnd_addr(), 32'h0); idle(1, 0); end
    join
    repeat (2) @(posedge clk);

    // Reset during the ACCESS of a port 1 read, then a tie
    issue(1, 0, 32'h10, 32'h0);
    @(posedge clk); #1 reset = 1'b1; bus.req1 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    fork
      begin issue(0, 0, 32'h14, 32'h0); idle(0, 0); end
      begin issue(1, 0, 32'h18, 32'h0); idle(1, 0); end
    join

    // Reset during the ACCESS of a write: the write still lands
    issue(0, 1, 32'h20, 32'h5A5A_A5A5);
    @(posedge clk); #1 reset = 1'b1; bus.req0 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    issue(1, 0, 32'h20, 32'h0); idle(1, 0);

    fork
      rnd_port(0, 60);
      rnd_port(1, 60);
    join

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk(q.size() == 0, "pending_responses", q.size(), 32'd0);
    bad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== shadow[i]) bad++;
    chk(bad == 0, "ram_contents", bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
